// File: rtl/regfile_32x32.sv
// regfile_32x32: 32-entry register storage, two async read ports, one sync write port.
// Ports: clk, reset (sync, active-high), write_enable/write_addr/write_data,
//        read_addr1/read_addr2 -> read_data1/read_data2 (combinational).
module regfile_32x32 #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_enable,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic [ADDR_BITS-1:0] read_addr1,
  input  logic [ADDR_BITS-1:0] read_addr2,
  output logic [WIDTH-1:0]     read_data1,
  output logic [WIDTH-1:0]     read_data2
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DEPTH-1:0]            we_oh;
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic                        fwd1;
  logic                        fwd2;
  logic                        zero1;
  logic                        zero2;

  // one-hot write enable; entry 0 never
  // decodes when it is the zero register
  always_comb begin
    we_oh = '0;
    if (write_enable) begin
      we_oh[write_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      we_oh[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_oh[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  assign zero1 = (ZERO_REG != 0)
              && (read_addr1 == '0);
  assign zero2 = (ZERO_REG != 0)
              && (read_addr2 == '0);

  // reset suppresses forwarding so reads
  // show pre-clear contents that cycle
  assign fwd1 = (BYPASS != 0)
             && write_enable && !reset
             && (write_addr == read_addr1);
  assign fwd2 = (BYPASS != 0)
             && write_enable && !reset
             && (write_addr == read_addr2);

  always_comb begin
    read_data1 = regs[read_addr1];
    if (fwd1) begin
      read_data1 = write_data;
    end
    if (zero1) begin
      read_data1 = '0;
    end
  end

  always_comb begin
    read_data2 = regs[read_addr2];
    if (fwd2) begin
      read_data2 = write_data;
    end
    if (zero2) begin
      read_data2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// tb_regfile_32x32: checks three configurations of regfile_32x32
// (default, ZERO_REG=0, BYPASS=1) against an array model.
module tb_regfile_32x32;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];

  int n_cmp;
  int n_bad;
  bit armed;

  int zr  [3] = '{1, 0, 1};
  int byp [3] = '{0, 0, 1};
  logic [31:0] mem [3][32];

  regfile_32x32 u_def (
    .clk(clk), .reset(reset),
    .write_enable(we), .write_addr(wa),
    .write_data(wd),
    .read_addr1(ra1), .read_addr2(ra2),
    .read_data1(rd1[0]), .read_data2(rd2[0])
  );

  regfile_32x32 #(.ZERO_REG(0)) u_nz (
    .clk(clk), .reset(reset),
    .write_enable(we), .write_addr(wa),
    .write_data(wd),
    .read_addr1(ra1), .read_addr2(ra2),
    .read_data1(rd1[1]), .read_data2(rd2[1])
  );

  regfile_32x32 #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .write_enable(we), .write_addr(wa),
    .write_data(wd),
    .read_addr1(ra1), .read_addr2(ra2),
    .read_data1(rd1[2]), .read_data2(rd2[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mexp(
    input int c, input logic [4:0] a);
    if (zr[c] != 0 && a == 5'd0) return 32'h0;
    if (byp[c] != 0 && we && !reset && wa == a)
      return wd;
    return mem[c][a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < 32; i++)
          mem[c][i] <= 32'h0;
      armed <= 1'b1;
    end else if (we) begin
      for (int c = 0; c < 3; c++)
        if (!(zr[c] != 0 && wa == 5'd0))
          mem[c][wa] <= wd;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int c = 0; c < 3; c++) begin
        chk($sformatf("model_rd1_cfg%0d", c),
            rd1[c], mexp(c, ra1));
        chk($sformatf("model_rd2_cfg%0d", c),
            rd2[c], mexp(c, ra2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a,
                    input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; armed = 1'b0;
    reset = 1'b1; we = 1'b0;
    wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    tick(); tick();
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      chk("reset_rd1", rd1[0], 32'h0);
      chk("reset_rd2", rd2[0], 32'h0);
      tick();
    end

    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    ra1 = 5'd5; ra2 = 5'd31; #1;
    chk("wr_r5", rd1[0], 32'hDEADBEEF);
    chk("wr_r31", rd2[0], 32'h12345678);
    ra1 = 5'd6; ra2 = 5'd30; #1;
    chk("other_r6", rd1[0], 32'h0);
    chk("other_r30", rd2[0], 32'h0);

    we = 1'b0; wa = 5'd7; wd = 32'hFFFFFFFF;
    tick(); tick(); tick();
    ra1 = 5'd7; ra2 = 5'd7; #1;
    chk("we0_r7_p1", rd1[0], 32'h0);
    chk("we0_r7_p2", rd2[0], 32'h0);

    wr(5'd0, 32'hAAAAAAAA);
    ra1 = 5'd0; ra2 = 5'd0; #1;
    chk("zr_on", rd1[0], 32'h0);
    chk("zr_off", rd1[1], 32'hAAAAAAAA);
    chk("zr_on_byp", rd2[2], 32'h0);

    ra1 = 5'd9; ra2 = 5'd5;
    we = 1'b1; wa = 5'd9; wd = 32'h0000BEEF;
    #1;
    chk("byp0_pre", rd1[0], 32'h0);
    chk("byp1_pre", rd1[2], 32'h0000BEEF);
    chk("byp1_other", rd2[2], 32'hDEADBEEF);
    tick();
    we = 1'b0; #1;
    chk("byp0_post", rd1[0], 32'h0000BEEF);
    chk("byp1_post", rd1[2], 32'h0000BEEF);

    wr(5'd3, 32'h55555555);
    ra1 = 5'd3; ra2 = 5'd5;
    reset = 1'b1;
    we = 1'b1; wa = 5'd3; wd = 32'h11111111;
    #1;
    chk("rst_nofwd", rd1[2], 32'h55555555);
    chk("rst_pre", rd1[0], 32'h55555555);
    tick();
    reset = 1'b0; we = 1'b0; #1;
    chk("rst_r3", rd1[0], 32'h0);
    chk("rst_r5", rd2[0], 32'h0);
    chk("rst_r3_nz", rd1[1], 32'h0);
    wr(5'd3, 32'h11111111);
    #1;
    chk("post_rst_wr", rd1[0], 32'h11111111);

    ra1 = 5'd3; ra2 = 5'd3; #1;
    chk("same_p1", rd1[0], 32'h11111111);
    chk("same_p2", rd2[0], 32'h11111111);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
